// File: rtl/j_target_encoder_pkg.sv
// Shared types and constants for the J-type target encoder.
// The optional JENC_SATURATE_EN macro is consumed by j_field_pack.
package j_target_encoder_pkg;

  localparam int J_FIELD_W = 26;
  localparam int OPC_W     = 6;

  localparam logic [J_FIELD_W-1:0] J_FIELD_MAX = 26'h1FF_FFFF;
  localparam logic [J_FIELD_W-1:0] J_FIELD_MIN = 26'h200_0000;

  typedef struct packed {
    logic [OPC_W-1:0]     opcode;
    logic [J_FIELD_W-1:0] field;
  } j_word_t;

  typedef struct packed {
    j_word_t word;
    logic    err;
  } j_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/j_target_encoder_field_pack.sv
// Combinational range check and field packing for a 32-bit signed jump target.
// With JENC_SATURATE_EN defined, out-of-range targets clamp to the field extremes.
module j_field_pack
  import j_target_encoder_pkg::*;
(
  input  logic [31:0]          target,
  output logic [J_FIELD_W-1:0] field,
  output logic                 err
);

  logic in_range;

  // A 26-bit signed value sign-extends to 32 bits only if bits 31..25 agree.
  assign in_range = (&target[31:25]) | ~(|target[31:25]);
  assign err      = ~in_range;

`ifdef JENC_SATURATE_EN
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    field = target[J_FIELD_W-1:0];
    if (!in_range) begin
      field = target[31] ? J_FIELD_MIN : J_FIELD_MAX;
    end
  end
`else
  assign field = target[J_FIELD_W-1:0];
`endif

endmodule

// File: rtl/j_target_encoder.sv
// Packs signed jump targets into {opcode, field} words through a 2-entry FIFO,
// with saturating accept/range-error counters. Optional macro: JENC_SATURATE_EN.
module j_target_encoder
  import j_target_encoder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [31:0]      in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             out_err,
  output logic [CNT_W-1:0] acc_count,
  output logic [CNT_W-1:0] err_count
);

  occ_e                 occ_q, occ_d;
  logic                 wr_ptr_q, rd_ptr_q;
  logic                 push, pop;
  logic [J_FIELD_W-1:0] pack_field;
  logic                 pack_err;
  j_entry_t             new_entry;
  j_entry_t             head;
  j_entry_t             mem [DEPTH];

  j_field_pack u_pack (
    .target (in_target),
    .field  (pack_field),
    .err    (pack_err)
  );

  assign new_entry = {in_opcode, pack_field, pack_err};

  assign in_ready  = reset && (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    unique case (occ_q)
      OCC_EMPTY: if (push) occ_d = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      occ_d = OCC_FULL;
        else if (pop && !push) occ_d = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) occ_d = OCC_ONE;
      default:   occ_d = OCC_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      occ_q     <= OCC_EMPTY;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      acc_count <= '0;
      err_count <= '0;
    end else begin
      occ_q <= occ_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      if (push && (acc_count != '1)) acc_count <= acc_count + CNT_W'(1);
      if (push && pack_err && (err_count != '1)) err_count <= err_count + CNT_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; outputs are masked by out_valid instead.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= new_entry;
  end

  assign head     = mem[rd_ptr_q];
  assign out_word = out_valid ? head.word : '0;
  assign out_err  = out_valid && head.err;

endmodule

// File: tb/tb_j_target_encoder.sv
// Self-checking bench: directed cases plus random traffic against a queue-based model.
module tb_j_target_encoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [31:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_err;
  logic [15:0] acc_count;
  logic [15:0] err_count;

  // Small-counter instance used to reach the saturation point quickly.
  logic        s_in_valid;
  logic        s_in_ready;
  logic [5:0]  s_opcode;
  logic [31:0] s_target;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_out_word;
  logic        s_out_err;
  logic [3:0]  s_acc;
  logic [3:0]  s_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q [$];
  int          exp_acc;
  int          exp_err;

  always #5 clock = ~clock;

  j_target_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_err(out_err),
    .acc_count(acc_count), .err_count(err_count)
  );

  j_target_encoder #(.DEPTH(2), .CNT_W(4)) dut_s (
    .clock(clock), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_opcode(s_opcode), .in_target(s_target),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_word(s_out_word), .out_err(s_out_err),
    .acc_count(s_acc), .err_count(s_err)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Expected {word, err} from the arithmetic meaning of the target.
  function automatic logic [32:0] model_entry(input logic [5:0] opc, input logic [31:0] tgt);
    int          s;
    logic        in_range;
    logic [25:0] field;
    s        = $signed(tgt);
    in_range = (s >= -33554432) && (s <= 33554431);
    field    = tgt[25:0];
`ifdef JENC_SATURATE_EN
    if (!in_range) field = (s < 0) ? 26'h200_0000 : 26'h1FF_FFFF;
`endif
    return {opc, field, ~in_range};
  endfunction

  task automatic compare_model();
    logic [32:0] h;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      check("out_word", out_word, h[32:1]);
      check("out_err", {31'd0, out_err}, {31'd0, h[0]});
    end
    check("acc_count", {16'd0, acc_count}, exp_acc);
    check("err_count", {16'd0, err_count}, exp_err);
  endtask

  // Called at a negedge: check, drive, advance the model, move to the next negedge.
  task automatic drive(input logic v, input logic [5:0] opc, input logic [31:0] tgt, input logic ordy);
    logic        do_pop;
    logic        do_push;
    logic [32:0] e;
    compare_model();
    in_valid  = v;
    in_opcode = opc;
    in_target = tgt;
    out_ready = ordy;
    do_pop    = ordy && (exp_q.size() > 0);
    do_push   = v && (exp_q.size() < 2);
    e         = model_entry(opc, tgt);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      exp_q.push_back(e);
      if (exp_acc < 65535) exp_acc++;
      if (e[0] && exp_err < 65535) exp_err++;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_acc", {16'd0, acc_count}, 32'd0);
    check("rst_err", {16'd0, err_count}, 32'd0);
    reset = 1'b1;
    #1;
    check("rst_in_ready_high", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    exp_acc = 0;
    exp_err = 0;
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] edges [6];
    edges = '{32'h01FF_FFFF, 32'hFE00_0000, 32'h0200_0000, 32'hFDFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    case ($urandom_range(0, 2))
      0:       return edges[$urandom_range(0, 5)];
      1:       return {{7{1'($urandom_range(0, 1))}}, 25'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] w;
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_opcode   = '0;
    in_target   = '0;
    out_ready   = 1'b0;
    s_in_valid  = 1'b0;
    s_opcode    = 6'h02;
    s_target    = 32'h4000_0000;
    s_out_ready = 1'b1;
    @(negedge clock);
    do_reset();

    // Case 1: in-range positive, one-cycle latency.
    drive(1'b1, 6'h02, 32'h0000_0010, 1'b0);
    check("c1_valid", {31'd0, out_valid}, 32'd1);
    check("c1_word", out_word, 32'h0800_0010);
    check("c1_err", {31'd0, out_err}, 32'd0);
    check("c1_acc", {16'd0, acc_count}, 32'd1);
    drive(1'b0, 6'h00, 32'h0, 1'b1);

    // Case 2: in-range negative, field sign-extends back to the target.
    drive(1'b1, 6'h02, 32'hFFFF_FFF0, 1'b0);
    check("c2_word", out_word, 32'h0BFF_FFF0);
    check("c2_err", {31'd0, out_err}, 32'd0);
    w = out_word;
    check("c2_sext", {{6{w[25]}}, w[25:0]}, 32'hFFFF_FFF0);
    drive(1'b0, 6'h00, 32'h0, 1'b1);

    // Case 3: out-of-range positive and negative.
    drive(1'b1, 6'h02, 32'h0200_0000, 1'b0);
    check("c3_err", {31'd0, out_err}, 32'd1);
    check("c3_errcnt", {16'd0, err_count}, 32'd1);
`ifdef JENC_SATURATE_EN
    check("c3_word_pos", out_word, 32'h09FF_FFFF);
`else
    check("c3_word_pos", out_word, 32'h0A00_0000);
`endif
    drive(1'b0, 6'h00, 32'h0, 1'b1);
    drive(1'b1, 6'h02, 32'hF000_0000, 1'b0);
`ifdef JENC_SATURATE_EN
    check("c3_word_neg", out_word, 32'h0A00_0000);
`else
    check("c3_word_neg", out_word, 32'h0800_0000);
`endif
    check("c3_errcnt2", {16'd0, err_count}, 32'd2);
    drive(1'b0, 6'h00, 32'h0, 1'b1);

    // Case 4: back-pressure, full buffer, ordered drain, push&pop at ONE.
    drive(1'b1, 6'h01, 32'h0000_0001, 1'b0);
    drive(1'b1, 6'h03, 32'h0000_0002, 1'b0);
    check("c4_full_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 6'h05, 32'h0000_0003, 1'b0);
    check("c4_head_first", out_word, 32'h0400_0001);
    drive(1'b1, 6'h05, 32'h0000_0003, 1'b1);
    check("c4_head_second", out_word, 32'h0C00_0002);
    drive(1'b1, 6'h05, 32'h0000_0003, 1'b1);
    check("c4_one_keeps_ready", {31'd0, in_ready}, 32'd1);
    check("c4_head_third", out_word, 32'h1400_0003);
    drive(1'b1, 6'h07, 32'h0000_0004, 1'b1);
    check("c4_pushpop_one", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 6'h00, 32'h0, 1'b1);

    // Case 5: reset with two words buffered.
    drive(1'b1, 6'h11, 32'h0000_0100, 1'b0);
    drive(1'b1, 6'h12, 32'h0000_0200, 1'b0);
    check("c5_full_before", {31'd0, in_ready}, 32'd0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 6'($urandom), pick_target(),
            1'($urandom_range(0, 2) != 0));
    end
    compare_model();

    // Case 6: counter saturation on the 4-bit instance (max 15).
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("c6_s_ready", {31'd0, s_in_ready}, 32'd1);
    s_in_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("c6_sat_acc", {28'd0, s_acc}, (i > 15) ? 32'd15 : 32'(i));
      check("c6_sat_err", {28'd0, s_err}, (i > 15) ? 32'd15 : 32'(i));
    end
    s_in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
